uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Multi-port UART transmit subsystem for SoC tops where several CPU IO ports (e.g. both lanes of a dual-issue core) write bytes to one serial line.
- Each port owns a byte FIFO; a round-robin arbiter drains the FIFOs into a single 8N1 serializer.
- Unlike the single-byte emitter, simultaneous writes never collide or drop silently: overflow is flagged per port.

Parameters:
- N_PORTS, 2, number of IO write ports (1..8).
- FIFO_DEPTH, 16, entries per port FIFO; power of 2, at least 2.
- CLK_FREQ_HZ, 50000000, clk frequency.
- BAUD_RATE, 230400, line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer divide), at least 2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- io_wr  in  N_PORTS  per-port write strobe, one byte per cycle per port.
- io_wdata  in  8*N_PORTS  port i byte at [8i+7:8i].
- io_ready  out  N_PORTS  port i FIFO not full.
- io_ovf  out  N_PORTS  sticky overflow flag for port i.
- tx_idle  out  1  all FIFOs empty and serializer IDLE.
- uart_tx  out  1  serial output; idles high.

Behaviour:
- Reset: asynchronous, active-low; effective immediately, including mid-frame.
  - uart_tx=1, io_ready=all 1, io_ovf=0, tx_idle=1.
  - FIFOs emptied, serializer in IDLE, round-robin pointer last=N_PORTS-1.
- FIFO write: accepted at a clk edge when io_wr[i] and count[i]<FIFO_DEPTH.
  - Fullness is taken from the registered count only. A pop from the same FIFO on the same edge does not make room for a write on that edge.
  - A write while full is discarded and sets io_ovf[i]=1; io_ovf clears only on reset.
  - io_ready[i] = !(count[i]==FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
- Arbitration: evaluated only when the serializer is IDLE.
  - Search ports last+1, last+2, … modulo N_PORTS; take the first with count>0.
  - On that edge: pop the head byte into the shift register, set last to that port, go to START.
  - A byte written on edge t is eligible from edge t+1, so uart_tx falls after edge t+1 at the earliest.
- Serializer FSM:
  - IDLE: uart_tx=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; a 3-bit index counts 0..7.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - The baud counter runs 0..CLKS_PER_BIT-1 and resets on every state change.
  - Next arbitration happens on the edge leaving STOP → IDLE. The following START begins one cycle later (one idle cycle between frames).
- uart_tx is a register output, glitch-free.
- tx_idle = serializer IDLE && all counts 0, combinational from registers.

Optional Feature:
- UART_PARITY_EN defined: a PARITY state between DATA and STOP drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bit-times.
- UART_PARITY_EN undefined: no PARITY state; 8N1, frame is 10 bit-times.

Test Plan (bench params CLK_FREQ_HZ=1000, BAUD_RATE=100 → 10 clks/bit, N_PORTS=2, FIFO_DEPTH=16):
1. Single byte: io_wr[0] with 0x55 at edge t → uart_tx low from after t+1 for 10 cycles, then 1,0,1,0,1,0,1,0 (10 cycles each), stop high 10 cycles. tx_idle returns to 1 after 100 cycles.
2. Collision: ports 0 and 1 write 0x41 and 0x42 on the same edge → frames 0x41 then 0x42, one idle cycle apart, io_ovf=0.
3. Fairness: port 0 writes 0xA0–0xA2 and port 1 writes 0xB0–0xB2 before the first frame starts → line order A0,B0,A1,B1,A2,B2.
4. Overflow: the serializer is busy with a port-0 frame; port 1 writes 17 bytes back-to-back.
   - After 16 writes, io_ready[1]=0. The 17th write → io_ovf[1]=1, that byte is never transmitted, io_ovf[0] stays 0.
   - After a pop, io_ready[1]=1 and io_ovf[1] stays 1.
5. Reset mid-frame: resetn low at bit 3 of a 0xFF frame with 4 bytes queued → uart_tx=1 with no clk edge, and after release tx_idle=1 and no further frames.
6. Parity (UART_PARITY_EN): 0x07 → parity bit 1. 0x03 → parity bit 0. Each frame is 110 cycles.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Multi-port UART transmitter: per-port byte FIFOs, round-robin drain into one serializer.
// Define UART_PARITY_EN to add an even-parity bit (8E1); the default build is 8N1.

module uart_tx_arb_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_wr,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_nempty,
    output logic       o_ready,
    output logic       o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          r_ovf;
    logic          w_full, w_push, w_pop;

    // Fullness comes from the registered count only, so a same-edge pop never frees a slot.
    assign w_full = (r_cnt == FULL);
    assign w_push = i_wr && !w_full;
    assign w_pop  = i_pop && (r_cnt != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push)          r_wp  <= r_wp + 1'b1;
            if (w_pop)           r_rp  <= r_rp + 1'b1;
            if (i_wr && w_full)  r_ovf <= 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_wdata;
    end

    assign o_head   = r_mem[r_rp];
    assign o_nempty = (r_cnt != '0);
    assign o_ready  = !w_full;
    assign o_ovf    = r_ovf;
endmodule

module uart_tx_arb #(
    parameter int N_PORTS     = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_RATE   = 230400
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_PORTS-1:0]   io_wr,
    input  logic [8*N_PORTS-1:0] io_wdata,
    output logic [N_PORTS-1:0]   io_ready,
    output logic [N_PORTS-1:0]   io_ovf,
    output logic                 tx_idle,
    output logic                 uart_tx
);
    localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BW  = $clog2(CPB);
    localparam int LW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [LW-1:0] LAST_RST  = LW'(N_PORTS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [LW-1:0] r_last, w_last_nxt;
    logic          r_tx, w_tx_nxt;

    logic [N_PORTS-1:0][7:0] w_head;
    logic [N_PORTS-1:0]      w_nempty, w_pop;
    logic [LW-1:0]           w_idx, w_sel;
    logic                    w_found, w_baud_done;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        uart_tx_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .resetn   (resetn),
            .i_wr     (io_wr[i]),
            .i_wdata  (io_wdata[8*i +: 8]),
            .i_pop    (w_pop[i]),
            .o_head   (w_head[i]),
            .o_nempty (w_nempty[i]),
            .o_ready  (io_ready[i]),
            .o_ovf    (io_ovf[i])
        );
    end

    // Round-robin search starting just after the last port served.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= N_PORTS; k++) begin
            w_idx = LW'((int'(r_last) + k) % N_PORTS);
            if (!w_found && w_nempty[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_PORTS; i++)
            w_pop[i] = (r_state == S_IDLE) && w_found && (w_sel == LW'(i));
    end

    assign w_baud_done = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_last  <= LAST_RST;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_last  <= w_last_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (w_found) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = w_head[w_sel];
                    w_last_nxt  = w_sel;
                end
            end
            S_START: if (w_baud_done) begin
                w_state_nxt = S_DATA;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
            S_DATA: if (w_baud_done) begin
                w_baud_nxt = '0;
                w_bit_nxt  = r_bit + 1'b1;
`ifdef UART_PARITY_EN
                if (r_bit == 3'd7) w_state_nxt = S_PARITY;
`else
                if (r_bit == 3'd7) w_state_nxt = S_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (w_baud_done) begin
                w_state_nxt = S_STOP;
                w_baud_nxt  = '0;
            end
`endif
            S_STOP: if (w_baud_done) begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so uart_tx comes straight off a flop.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[w_bit_nxt];
            S_PARITY: w_tx_nxt = ^w_shift_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign uart_tx = r_tx;
    assign tx_idle = (r_state == S_IDLE) && !(|w_nempty);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: line receiver + round-robin queue model; honours UART_PARITY_EN.
module tb_uart_tx_arb;
    localparam int NP = 2;
    localparam int CPB = 10;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = CPB * NB;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [NP-1:0]   io_wr = '0;
    logic [8*NP-1:0] io_wdata = '0;
    logic [NP-1:0]   io_ready, io_ovf;
    logic            tx_idle, uart_tx;

    uart_tx_arb #(.N_PORTS(NP), .FIFO_DEPTH(16), .CLK_FREQ_HZ(1000), .BAUD_RATE(100)) dut (
        .clk(clk), .resetn(resetn), .io_wr(io_wr), .io_wdata(io_wdata),
        .io_ready(io_ready), .io_ovf(io_ovf), .tx_idle(tx_idle), .uart_tx(uart_tx));

    always #5 clk = ~clk;

    int cyc = 0;
    int rst_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge resetn) rst_cnt <= rst_cnt + 1;

    int vectors = 0, errors = 0;
    logic [7:0] rx_q[$];
    bit         rx_ok[$];
    int         rx_t[$];
    int         n_starts = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mq[NP][64];
    int         mh[NP], mt[NP];
    int         mlast = NP - 1;

    // Line receiver: samples mid-bit, drops any frame interrupted by reset.
    initial begin
        logic prev;
        logic [10:0] bits;
        int rc, st;
        bit ab, ok;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && prev === 1'b1 && uart_tx === 1'b0) begin
                n_starts++;
                rc = rst_cnt; st = cyc; ab = 0; bits = '0;
                for (int c = 0; c < (NB-1)*CPB + CPB/2; c++) begin
                    @(negedge clk);
                    if (rst_cnt != rc) begin ab = 1; break; end
                    if (c % CPB == CPB/2 - 1) bits[c/CPB] = uart_tx;
                end
                ok = (bits[0] == 1'b0) && (bits[NB-1] == 1'b1) && (NB == 10 || bits[9] == ^bits[8:1]);
                if (!ab) begin rx_q.push_back(bits[8:1]); rx_ok.push_back(ok); rx_t.push_back(st); end
            end
            prev = uart_tx;
        end
    end

    function automatic logic exp_line(input int j, input logic [7:0] b);
        int k;
        k = j / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        for (int q = 0; q < NP; q++) begin mh[q] = 0; mt[q] = 0; end
        mlast = NP - 1;
    endtask

    // Expected line order: first pick only sees the first-edge writers, later picks see all.
    task automatic model_run(input logic [NP-1:0] fm);
        int p;
        p = -1;
        for (int k = 1; k <= NP; k++) if (p < 0 && fm[(mlast+k)%NP]) p = (mlast + k) % NP;
        while (p >= 0) begin
            exp_q.push_back(mq[p][mh[p]]);
            mh[p]++;
            mlast = p;
            p = -1;
            for (int k = 1; k <= NP; k++)
                if (p < 0 && mh[(mlast+k)%NP] < mt[(mlast+k)%NP]) p = (mlast + k) % NP;
        end
        for (int q = 0; q < NP; q++) begin mh[q] = 0; mt[q] = 0; end
    endtask

    task automatic do_write(input logic [NP-1:0] m, input logic [8*NP-1:0] d);
        @(negedge clk);
        io_wr = m; io_wdata = d;
        for (int p = 0; p < NP; p++) if (m[p]) begin mq[p][mt[p]] = d[8*p +: 8]; mt[p]++; end
        @(posedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (tx_idle !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        vectors++;
        if (tx_idle !== 1'b1) begin errors++; $display("FAIL wait_idle: tx_idle=%b after %0d cycles, required 1", tx_idle, n); end
    endtask

    task automatic apply_reset();
        @(negedge clk); resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", uart_tx); end
        vectors++; if (io_ready !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b, required 11", io_ready); end
        vectors++; if (io_ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b, required 00", io_ovf); end
        vectors++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b, required 1", tx_idle); end
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic test_single();
        logic [7:0] b;
        b = 8'h55;
        do_write(2'b01, {8'h00, b});
        @(negedge clk); io_wr = '0;
        vectors++; if (uart_tx !== 1'b1 || tx_idle !== 1'b0) begin errors++; $display("FAIL single_pre: tx=%b idle=%b, required 1/0", uart_tx, tx_idle); end
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            vectors++;
            if (uart_tx !== exp_line(j, b)) begin errors++; $display("FAIL single_wave: cycle %0d got %b, required %b", j, uart_tx, exp_line(j, b)); end
        end
        vectors++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL single_idle_early: got %b, required 0", tx_idle); end
        @(negedge clk);
        vectors++; if (tx_idle !== 1'b1 || uart_tx !== 1'b1) begin errors++; $display("FAIL single_idle: idle=%b tx=%b, required 1/1", tx_idle, uart_tx); end
        model_run(2'b01);
        while (exp_q.size() > 0) begin
            vectors++;
            if (rx_q.size() == 0) begin errors++; $display("FAIL single_rx: nothing received, required %h", exp_q[0]); end
            else begin
                if (rx_q[0] !== exp_q[0] || !rx_ok[0]) begin errors++; $display("FAIL single_rx: got %h framing_ok=%0d, required %h", rx_q[0], rx_ok[0], exp_q[0]); end
                void'(rx_q.pop_front()); void'(rx_ok.pop_front()); void'(rx_t.pop_front());
            end
            void'(exp_q.pop_front());
        end
        vectors++; if (rx_q.size() != 0) begin errors++; $display("FAIL single_extra: %0d extra frames, required 0", rx_q.size()); end
    endtask

    task automatic test_collision();
        apply_reset();
        do_write(2'b11, {8'h42, 8'h41});
        @(negedge clk); io_wr = '0;
        model_run(2'b11);
        wait_idle(3 * (FRAME + 1) + 20);
        vectors++; if (io_ovf !== 2'b00) begin errors++; $display("FAIL collision_ovf: got %b, required 00", io_ovf); end
        vectors++;
        if (rx_t.size() < 2) begin errors++; $display("FAIL collision_gap: only %0d frames, required 2", rx_t.size()); end
        else if (rx_t[1] - rx_t[0] != FRAME + 1) begin errors++; $display("FAIL collision_gap: got %0d cycles, required %0d", rx_t[1] - rx_t[0], FRAME + 1); end
        while (exp_q.size() > 0) begin
            vectors++;
            if (rx_q.size() == 0) begin errors++; $display("FAIL collision_rx: nothing received, required %h", exp_q[0]); end
            else begin
                if (rx_q[0] !== exp_q[0] || !rx_ok[0]) begin errors++; $display("FAIL collision_rx: got %h framing_ok=%0d, required %h", rx_q[0], rx_ok[0], exp_q[0]); end
                void'(rx_q.pop_front()); void'(rx_ok.pop_front()); void'(rx_t.pop_front());
            end
            void'(exp_q.pop_front());
        end
        vectors++; if (rx_q.size() != 0) begin errors++; $display("FAIL collision_extra: %0d extra frames, required 0", rx_q.size()); end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 3; i++) do_write(2'b11, {8'hB0 + 8'(i), 8'hA0 + 8'(i)});
        @(negedge clk); io_wr = '0;
        model_run(2'b11);
        wait_idle(7 * (FRAME + 1) + 20);
        while (exp_q.size() > 0) begin
            vectors++;
            if (rx_q.size() == 0) begin errors++; $display("FAIL fairness_rx: nothing received, required %h", exp_q[0]); end
            else begin
                if (rx_q[0] !== exp_q[0] || !rx_ok[0]) begin errors++; $display("FAIL fairness_rx: got %h framing_ok=%0d, required %h", rx_q[0], rx_ok[0], exp_q[0]); end
                void'(rx_q.pop_front()); void'(rx_ok.pop_front()); void'(rx_t.pop_front());
            end
            void'(exp_q.pop_front());
        end
        vectors++; if (rx_q.size() != 0) begin errors++; $display("FAIL fairness_extra: %0d extra frames, required 0", rx_q.size()); end
    endtask

    task automatic test_random();
        logic [NP-1:0] m, fm;
        int ncyc;
        for (int r = 0; r < 4; r++) begin
            ncyc = $urandom_range(1, 6);
            fm = '0;
            for (int c = 0; c < ncyc; c++) begin
                m = (c == 0) ? NP'($urandom_range(1, 3)) : NP'($urandom_range(0, 3));
                if (c == 0) fm = m;
                do_write(m, 16'($urandom));
            end
            @(negedge clk); io_wr = '0;
            model_run(fm);
            wait_idle(13 * (FRAME + 1) + 20);
            while (exp_q.size() > 0) begin
                vectors++;
                if (rx_q.size() == 0) begin errors++; $display("FAIL random_rx: round %0d nothing received, required %h", r, exp_q[0]); end
                else begin
                    if (rx_q[0] !== exp_q[0] || !rx_ok[0]) begin errors++; $display("FAIL random_rx: round %0d got %h framing_ok=%0d, required %h", r, rx_q[0], rx_ok[0], exp_q[0]); end
                    void'(rx_q.pop_front()); void'(rx_ok.pop_front()); void'(rx_t.pop_front());
                end
                void'(exp_q.pop_front());
            end
            vectors++; if (rx_q.size() != 0) begin errors++; $display("FAIL random_extra: round %0d %0d extra frames", r, rx_q.size()); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        int n;
        do_write(2'b01, {8'h00, 8'($urandom)});
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 15) begin
                vectors++; if (io_ready[1] !== 1'b1) begin errors++; $display("FAIL ovf_ready15: got %b, required 1", io_ready[1]); end
            end
            if (i == 16) begin
                vectors++; if (io_ready[1] !== 1'b0) begin errors++; $display("FAIL ovf_ready16: got %b, required 0", io_ready[1]); end
                vectors++; if (io_ovf !== 2'b00) begin errors++; $display("FAIL ovf_early: got %b, required 00", io_ovf); end
            end
            d = 8'($urandom);
            io_wr = 2'b10; io_wdata = {d, 8'h00};
            if (i < 16) begin mq[1][mt[1]] = d; mt[1]++; end
            @(posedge clk);
        end
        @(negedge clk); io_wr = '0;
        vectors++; if (io_ovf !== 2'b10) begin errors++; $display("FAIL ovf_flag: got %b, required 10", io_ovf); end
        vectors++; if (io_ready !== 2'b01) begin errors++; $display("FAIL ovf_ready: got %b, required 01", io_ready); end
        n = 0;
        while (io_ready[1] !== 1'b1 && n < 2 * FRAME) begin @(negedge clk); n++; end
        vectors++; if (io_ready[1] !== 1'b1) begin errors++; $display("FAIL ovf_pop_ready: got %b after %0d cycles, required 1", io_ready[1], n); end
        vectors++; if (io_ovf !== 2'b10) begin errors++; $display("FAIL ovf_sticky: got %b, required 10", io_ovf); end
        model_run(2'b01);
        wait_idle(18 * (FRAME + 1) + 20);
        while (exp_q.size() > 0) begin
            vectors++;
            if (rx_q.size() == 0) begin errors++; $display("FAIL ovf_rx: nothing received, required %h", exp_q[0]); end
            else begin
                if (rx_q[0] !== exp_q[0] || !rx_ok[0]) begin errors++; $display("FAIL ovf_rx: got %h framing_ok=%0d, required %h", rx_q[0], rx_ok[0], exp_q[0]); end
                void'(rx_q.pop_front()); void'(rx_ok.pop_front()); void'(rx_t.pop_front());
            end
            void'(exp_q.pop_front());
        end
        vectors++; if (rx_q.size() != 0) begin errors++; $display("FAIL ovf_extra: %0d extra frames, required 0", rx_q.size()); end
    endtask

    task automatic test_reset_midframe();
        int base;
        do_write(2'b01, {8'h00, 8'hFF});
        do_write(2'b11, 16'($urandom));
        do_write(2'b11, 16'($urandom));
        @(negedge clk); io_wr = '0;
        repeat (43) @(negedge clk);
        vectors++; if (uart_tx !== 1'b1 || tx_idle !== 1'b0) begin errors++; $display("FAIL mid_pre: tx=%b idle=%b, required 1/0", uart_tx, tx_idle); end
        #2 resetn = 1'b0;
        #1;
        vectors++; if (uart_tx !== 1'b1 || tx_idle !== 1'b1) begin errors++; $display("FAIL mid_async: tx=%b idle=%b, required 1/1", uart_tx, tx_idle); end
        vectors++; if (io_ready !== 2'b11 || io_ovf !== 2'b00) begin errors++; $display("FAIL mid_flags: ready=%b ovf=%b, required 11/00", io_ready, io_ovf); end
        @(negedge clk); resetn = 1'b1;
        base = n_starts;
        repeat (2 * FRAME) @(negedge clk);
        vectors++; if (n_starts != base || tx_idle !== 1'b1) begin errors++; $display("FAIL mid_quiet: %0d new frames idle=%b, required 0/1", n_starts - base, tx_idle); end
        do_write(2'b01, 16'($urandom));
        @(negedge clk); io_wr = '0;
        repeat (4) @(negedge clk);
        vectors++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL start_bit: got %b, required 0", uart_tx); end
        #2 resetn = 1'b0;
        #1;
        vectors++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL start_async: got %b, required 1", uart_tx); end
        @(negedge clk); resetn = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        vectors++; if (n_starts != base + 1 || rx_q.size() != 0 || tx_idle !== 1'b1) begin
            errors++; $display("FAIL start_quiet: starts=%0d rx=%0d idle=%b, required %0d/0/1", n_starts - base, rx_q.size(), tx_idle, 1);
        end
        model_clear();
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        logic pe;
        for (int i = 0; i < 2; i++) begin
            b  = (i == 0) ? 8'h07 : 8'h03;
            pe = (i == 0) ? 1'b1 : 1'b0;
            do_write(2'b01, {8'h00, b});
            @(negedge clk); io_wr = '0;
            repeat (96) @(negedge clk);
            vectors++; if (uart_tx !== pe) begin errors++; $display("FAIL parity_bit: byte %h got %b, required %b", b, uart_tx, pe); end
            repeat (14) @(negedge clk);
            vectors++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL parity_len: byte %h idle early, required 0", b); end
            @(negedge clk);
            vectors++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL parity_end: byte %h idle=%b, required 1", b, tx_idle); end
            model_run(2'b01);
        end
        while (exp_q.size() > 0) begin
            vectors++;
            if (rx_q.size() == 0) begin errors++; $display("FAIL parity_rx: nothing received, required %h", exp_q[0]); end
            else begin
                if (rx_q[0] !== exp_q[0] || !rx_ok[0]) begin errors++; $display("FAIL parity_rx: got %h framing_ok=%0d, required %h", rx_q[0], rx_ok[0], exp_q[0]); end
                void'(rx_q.pop_front()); void'(rx_ok.pop_front()); void'(rx_t.pop_front());
            end
            void'(exp_q.pop_front());
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d miscompares so far", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_fairness();
        test_random();
        test_overflow();
        test_reset_midframe();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
